// File: rtl/intcvtnorm.sv
// intcvtnorm: integer magnitude + iterative normalization front end for int-to-FP conversion
// Ports: clk/resetn (sync active-low), Flush aborts; InValid/InReady accept IntIn with Signed/Int64;
// OutValid/OutReady deliver Xs (sign), Mant (normalized magnitude), Lz (leading zeros), Zero.
module intcvtnorm #(
  parameter int XLEN = 64
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    Flush,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [XLEN-1:0]         IntIn,
  input  logic                    Signed,
  input  logic                    Int64,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic                    Xs,
  output logic [XLEN-1:0]         Mant,
  output logic [$clog2(XLEN):0]   Lz,
  output logic                    Zero
);
  localparam int LW = $clog2(XLEN) + 1;
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
  state_t          r_state, w_next;
  logic            r_xs, r_zero, w_s;
  logic [XLEN-1:0] r_mant, w_ext;
  logic [LW-1:0]   r_lz;
  // 32-bit operands are sign/zero extended into the upper word
  assign w_ext    = Int64 ? IntIn : (({XLEN{Signed & IntIn[31]}} << 32) | XLEN'(IntIn[31:0]));
  assign w_s      = Signed & w_ext[XLEN-1];
  assign InReady  = r_state == IDLE;
  assign OutValid = r_state == DONE;
  assign Xs       = r_xs;
  assign Mant     = r_mant;
  assign Lz       = r_lz;
  assign Zero     = r_zero;
  always_comb begin
    w_next = Flush ? IDLE :
             (r_state == IDLE) ? (InValid ? NORM : IDLE) :
             (r_state == NORM) ? ((r_mant == '0 || r_mant[XLEN-1]) ? DONE : NORM) :
             (OutReady ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_xs    <= 1'b0;
      r_mant  <= '0;
      r_lz    <= '0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (!Flush && r_state == IDLE && InValid) begin
        r_xs   <= w_s;
        r_mant <= w_s ? -w_ext : w_ext;
        r_lz   <= '0;
        r_zero <= 1'b0;
      end else if (!Flush && r_state == NORM) begin
        if (r_mant == '0) begin
          r_zero <= 1'b1;
          r_xs   <= 1'b0;
          r_lz   <= '0;
        end else if (!r_mant[XLEN-1]) begin
          // coarse byte steps first, then single-bit steps for the last few zeros
          r_mant <= (r_mant[XLEN-1 -: 8] == '0) ? r_mant << 8 : r_mant << 1;
          r_lz   <= r_lz + ((r_mant[XLEN-1 -: 8] == '0) ? LW'(8) : LW'(1));
        end
      end
    end
  end
endmodule

// File: tb/tb_intcvtnorm.sv
// tb_intcvtnorm: directed + scoreboard bench for intcvtnorm (XLEN=64)
module tb_intcvtnorm;
  logic        clk = 0, resetn = 0, Flush = 0, InValid = 0, Signed = 0, Int64 = 0, OutReady = 0;
  logic [63:0] IntIn = '0;
  logic        InReady, OutValid, Xs, Zero;
  logic [63:0] Mant;
  logic [6:0]  Lz;
  int          checks = 0, errors = 0;
  typedef struct {logic xs; logic [63:0] mant; int lz; logic zero; int n;} exp_t;
  exp_t q[$];

  intcvtnorm #(.XLEN(64)) dut (
    .clk(clk), .resetn(resetn), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .IntIn(IntIn), .Signed(Signed), .Int64(Int64), .OutValid(OutValid), .OutReady(OutReady),
    .Xs(Xs), .Mant(Mant), .Lz(Lz), .Zero(Zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic i64, input logic sg, input logic [63:0] x);
    exp_t r;
    logic [63:0] e, m;
    logic s;
    int lz;
    e = i64 ? x : {{32{sg & x[31]}}, x[31:0]};
    s = sg & e[63];
    m = s ? (~e + 64'd1) : e;
    if (m == 0) begin
      r = '{1'b0, 64'd0, 0, 1'b1, 1};
      return r;
    end
    lz = 0;
    while (!m[63]) begin
      m = m << 1;
      lz++;
    end
    r = '{s, m, lz, 1'b0, 1 + lz / 8 + lz % 8};
    return r;
  endfunction

  task automatic issue(input logic i64, input logic sg, input logic [63:0] x);
    @(negedge clk);
    chk("in_ready_before_issue", 64'(InReady), 64'd1);
    Int64 = i64; Signed = sg; IntIn = x; InValid = 1;
    q.push_back(model(i64, sg, x));
    @(negedge clk);
    InValid = 0;
  endtask

  task automatic run_op(input logic i64, input logic sg, input logic [63:0] x, input int hold);
    exp_t e;
    int cyc;
    issue(i64, sg, x);
    cyc = 1;
    while (!OutValid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    e = q.pop_front();
    chk("latency", 64'(cyc), 64'(e.n + 1));
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 64'(OutValid), 64'd1);
      chk("hold_ready", 64'(InReady), 64'd0);
      chk("hold_mant", Mant, e.mant);
      chk("hold_lz", 64'(Lz), 64'(e.lz));
      @(negedge clk);
    end
    chk("xs", 64'(Xs), 64'(e.xs));
    chk("mant", Mant, e.mant);
    chk("lz", 64'(Lz), 64'(e.lz));
    chk("zero", 64'(Zero), 64'(e.zero));
    OutReady = 1;
    @(negedge clk);
    OutReady = 0;
    chk("post_valid", 64'(OutValid), 64'd0);
    chk("post_ready", 64'(InReady), 64'd1);
  endtask

  task automatic abort_op(input logic use_reset);
    int seen;
    issue(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (3) @(negedge clk);
    if (use_reset) resetn = 0; else Flush = 1;
    @(negedge clk);
    resetn = 1; Flush = 0;
    void'(q.pop_back());
    chk("abort_valid", 64'(OutValid), 64'd0);
    chk("abort_ready", 64'(InReady), 64'd1);
    if (use_reset) chk("abort_mant", Mant, 64'd0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (OutValid) seen++;
    end
    chk("no_stale_result", 64'(seen), 64'd0);
    run_op(1'b1, 1'b0, 64'h1, 0);
  endtask

  initial begin
    InValid = 1; IntIn = 64'h1234; Int64 = 1;
    repeat (3) @(negedge clk);
    InValid = 0;
    resetn = 1;
    @(negedge clk);
    chk("rst_valid", 64'(OutValid), 64'd0);
    chk("rst_ready", 64'(InReady), 64'd1);
    chk("rst_mant", Mant, 64'd0);
    chk("rst_lz", 64'(Lz), 64'd0);
    chk("rst_xs", 64'(Xs), 64'd0);
    chk("rst_zero", 64'(Zero), 64'd0);
    Flush = 1; InValid = 1;
    @(negedge clk);
    Flush = 0; InValid = 0;
    chk("flush_ignores_in", 64'(InReady), 64'd1);
    run_op(1'b1, 1'b0, 64'h8000_0000_0000_0000, 0);
    run_op(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op(1'b0, 1'b1, 64'h0000_0000_8000_0000, 0);
    run_op(1'b0, 1'b0, 64'h0000_0000_8000_0000, 0);
    run_op(1'b1, 1'b1, 64'h0, 0);
    run_op(1'b1, 1'b0, 64'h0000_0000_0000_00F0, 10);
    run_op(1'b1, 1'b1, 64'h8000_0000_0000_0000, 1);
    run_op(1'b0, 1'b1, 64'hDEAD_BEEF_FFFF_FFFE, 2);
    for (int i = 0; i < 6; i++)
      run_op(1'($urandom), 1'($urandom), {32'($urandom) >> $urandom_range(0, 31), 32'($urandom)} >> $urandom_range(0, 63), $urandom_range(0, 2));
    abort_op(1'b1);
    abort_op(1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
